// File: rtl/bram_sdp_pipelined.sv
// Simple dual-port block RAM with per-byte write enables, read enable with valid flag,
// selectable read-during-write behaviour and an optional second output register stage.
module bram_sdp_pipelined #(
   parameter int ADDR_WIDTH   = 3,
   parameter int DATA_WIDTH   = 32,
   parameter int BYTE_WIDTH   = 8,
   parameter int READ_LATENCY = 1,
   parameter int RDW_MODE     = 0
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we,
   input  logic [ADDR_WIDTH-1:0]            addr_w,
   input  logic [DATA_WIDTH-1:0]            din,
   input  logic                             rd_en,
   input  logic [ADDR_WIDTH-1:0]            addr_r,
   output logic [DATA_WIDTH-1:0]            dout,
   output logic                             rd_valid
);

   localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH     = 1 << ADDR_WIDTH;

   generate
      if ((READ_LATENCY != 32'sd1) && (READ_LATENCY != 32'sd2)) begin : g_bad_latency
         $error("bram_sdp_pipelined: READ_LATENCY must be 1 or 2");
      end
      if ((DATA_WIDTH % BYTE_WIDTH) != 32'sd0) begin : g_bad_bytes
         $error("bram_sdp_pipelined: DATA_WIDTH must be a multiple of BYTE_WIDTH");
      end
   endgenerate

   // Replace the enabled bytes of old_word with the matching bytes of new_word.
   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [NUM_BYTES-1:0]  be
   );
      logic [DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 32'sd0; i < NUM_BYTES; i++) begin
         if (be[i]) begin
            merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      return merged;
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [NUM_BYTES-1:0]  wr_en_s;
   logic                  collide_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic [DATA_WIDTH-1:0] rd_data1_r;
   logic                  rd_valid1_r;

   // Write-enable gating: no byte lands in the array while reset is held.
   always_comb begin
      wr_en_s = {NUM_BYTES{1'b0}};
      if (reset_n) begin
         wr_en_s = we;
      end else begin
         wr_en_s = {NUM_BYTES{1'b0}};
      end
   end

   // Byte-granular array write; the array itself is never reset so it maps to block RAM.
   always_ff @(posedge clk) begin
      for (int i = 32'sd0; i < NUM_BYTES; i++) begin
         if (wr_en_s[i]) begin
            mem_r[addr_w][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   assign collide_s = (addr_w == addr_r) && (|we);

   // Read word selection: write-first mode forwards the enabled bytes of a same-address write.
   always_comb begin
      rd_word_s = mem_r[addr_r];
      if ((RDW_MODE == 32'sd1) && collide_s) begin
         rd_word_s = merge_bytes(mem_r[addr_r], din, we);
      end else begin
         rd_word_s = mem_r[addr_r];
      end
   end

   // Stage-1 read register; data holds its value whenever no read is issued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data1_r  <= {DATA_WIDTH{1'b0}};
         rd_valid1_r <= 1'b0;
      end else begin
         rd_valid1_r <= rd_en;
         if (rd_en) begin
            rd_data1_r <= rd_word_s;
         end
      end
   end

   generate
      if (READ_LATENCY == 32'sd2) begin : g_lat2
         logic [DATA_WIDTH-1:0] rd_data2_r;
         logic                  rd_valid2_r;

         // Stage-2 output register for timing closure; data only moves with a valid word.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rd_data2_r  <= {DATA_WIDTH{1'b0}};
               rd_valid2_r <= 1'b0;
            end else begin
               rd_valid2_r <= rd_valid1_r;
               if (rd_valid1_r) begin
                  rd_data2_r <= rd_data1_r;
               end
            end
         end

         assign dout     = rd_data2_r;
         assign rd_valid = rd_valid2_r;
      end else begin : g_lat1
         assign dout     = rd_data1_r;
         assign rd_valid = rd_valid1_r;
      end
   endgenerate

endmodule
